// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: D = A - B, one bit per clock, LSB first, with a
// start/done handshake and an unsigned borrow flag.
module serial_subtractor #(
  parameter int SIZE = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [SIZE-1:0] d,
  output logic            bf,
  output logic [1:0]      fsm_state
);

  // Handshake: start is accepted on a rising edge only in IDLE or DONE; it is
  // ignored while busy. done is a single-cycle pulse and never overlaps busy.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int CW = $clog2(SIZE);

  state_t          state;
  state_t          next_state;
  logic [SIZE-1:0] a_sr;
  logic [SIZE-1:0] b_sr;
  logic [SIZE-1:0] r_sr;
  logic [CW-1:0]   cnt;
  logic            br;
  logic            bit_d;
  logic            br_next;
  logic            load;
  logic            last;

  assign fsm_state = state;

  always_comb begin
    bit_d   = a_sr[0] ^ b_sr[0] ^ br;
    br_next = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
  end

  always_comb begin
    next_state = state;
    busy       = 1'b0;
    done       = 1'b0;
    load       = 1'b0;
    last       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          next_state = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (cnt == CW'(SIZE - 1)) begin
          last       = 1'b1;
          next_state = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          load       = 1'b1;
          next_state = SHIFT;
        end else begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr <= '0;
      b_sr <= '0;
      r_sr <= '0;
      cnt  <= '0;
      br   <= 1'b0;
      d    <= '0;
      bf   <= 1'b0;
    end else if (load) begin
      a_sr <= a;
      b_sr <= b;
      r_sr <= '0;
      cnt  <= '0;
      br   <= 1'b0;
    end else if (busy) begin
      // Result bits enter at the MSB so bit 0 lands in place after SIZE shifts.
      a_sr <= a_sr >> 1;
      b_sr <= b_sr >> 1;
      r_sr <= {bit_d, r_sr[SIZE-1:1]};
      br   <= br_next;
      cnt  <= cnt + CW'(1);
      if (last) begin
        d  <= {bit_d, r_sr[SIZE-1:1]};
        bf <= br_next;
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: vector table at SIZE=4, corner
// sequences (ignored start, back-to-back, async reset) and SIZE=8 vectors.
module tb_serial_subtractor;

  logic       clk;
  logic       rst_n;
  logic       start4, start8;
  logic [3:0] a4, b4, d4;
  logic [7:0] a8, b8, d8;
  logic       busy4, done4, bf4, busy8, done8, bf8;
  logic [1:0] st4, st8;

  logic       sel8;
  logic       busy_s, done_s, bf_s;
  logic [7:0] d_s;

  int n_checks;
  int n_pass;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp_d;
    logic       exp_bf;
  } vec_t;

  vec_t vecs4[6];
  vec_t vecs8[2];
  vec_t b2b[4];

  serial_subtractor #(.SIZE(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .d(d4), .bf(bf4), .fsm_state(st4)
  );

  serial_subtractor #(.SIZE(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .d(d8), .bf(bf8), .fsm_state(st8)
  );

  assign busy_s = sel8 ? busy8 : busy4;
  assign done_s = sel8 ? done8 : done4;
  assign bf_s   = sel8 ? bf8 : bf4;
  assign d_s    = sel8 ? d8 : {4'b0, d4};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endfunction

  task automatic drive(input logic s, input logic [7:0] x, input logic [7:0] y);
    if (sel8) begin
      start8 = s; a8 = x; b8 = y;
    end else begin
      start4 = s; a4 = x[3:0]; b4 = y[3:0];
    end
  endtask

  // One start pulse, then count busy cycles until done (bounded), check result
  // and that d/bf hold one cycle later.
  task automatic run_op(input vec_t v);
    int cyc;
    int busy_cnt;
    int size;
    size = sel8 ? 8 : 4;
    @(negedge clk);
    drive(1'b1, v.a, v.b);
    @(negedge clk);
    drive(1'b0, 8'hA5, 8'h5A);
    cyc = 0;
    busy_cnt = 0;
    while (!done_s && cyc < 40) begin
      if (busy_s) busy_cnt++;
      @(negedge clk);
      cyc++;
    end
    check("op_latency", 32'(cyc), 32'(size));
    check("op_busy_cycles", 32'(busy_cnt), 32'(size));
    check("op_busy_at_done", 32'(busy_s), 32'd0);
    check("op_d", 32'(d_s), 32'(v.exp_d));
    check("op_bf", 32'(bf_s), 32'(v.exp_bf));
    @(negedge clk);
    check("op_done_pulse", 32'(done_s), 32'd0);
    check("op_d_hold", 32'(d_s), 32'(v.exp_d));
    check("op_bf_hold", 32'(bf_s), 32'(v.exp_bf));
  endtask

  initial begin
    int cyc;
    int dones;
    n_checks = 0;
    n_pass   = 0;
    sel8 = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0;
    start8 = 1'b0; a8 = '0; b8 = '0;

    vecs4[0] = '{8'd7,  8'd3,  8'd4,  1'b0};
    vecs4[1] = '{8'd3,  8'd7,  8'd12, 1'b1};
    vecs4[2] = '{8'd0,  8'd1,  8'd15, 1'b1};
    vecs4[3] = '{8'd15, 8'd15, 8'd0,  1'b0};
    vecs4[4] = '{8'd0,  8'd0,  8'd0,  1'b0};
    vecs4[5] = '{8'd12, 8'd5,  8'd7,  1'b0};
    vecs8[0] = '{8'd200, 8'd55,  8'd145, 1'b0};
    vecs8[1] = '{8'd55,  8'd200, 8'd111, 1'b1};
    b2b[0]   = '{8'd5,  8'd9, 8'd12, 1'b1};
    b2b[1]   = '{8'd14, 8'd3, 8'd11, 1'b0};
    b2b[2]   = '{8'd8,  8'd8, 8'd0,  1'b0};
    b2b[3]   = '{8'd1,  8'd2, 8'd15, 1'b1};

    // Reset state
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy4", 32'(busy4), 32'd0);
    check("rst_done4", 32'(done4), 32'd0);
    check("rst_d4", 32'(d4), 32'd0);
    check("rst_bf4", 32'(bf4), 32'd0);
    check("rst_busy8", 32'(busy8), 32'd0);
    check("rst_d8", 32'(d8), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_no_done", 32'(done4), 32'd0);

    for (int i = 0; i < 6; i++) run_op(vecs4[i]);

    // Start during SHIFT must be ignored: one done carrying 9-2
    @(negedge clk);
    drive(1'b1, 8'd9, 8'd2);
    @(negedge clk);
    drive(1'b0, 8'd0, 8'd0);
    @(negedge clk);
    drive(1'b1, 8'd1, 8'd1);
    @(negedge clk);
    drive(1'b0, 8'd0, 8'd0);
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      if (done4) begin
        dones++;
        check("ign_d", 32'(d4), 32'd7);
        check("ign_bf", 32'(bf4), 32'd0);
      end
      @(negedge clk);
    end
    check("ign_done_count", 32'(dones), 32'd1);

    // start held high: a result every SIZE+1 cycles, operands taken at each E0
    @(negedge clk);
    drive(1'b1, b2b[0].a, b2b[0].b);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("b2b_busy", 32'(busy4), 32'd1);
      if (k < 3) drive(1'b1, b2b[k+1].a, b2b[k+1].b);
      else       drive(1'b0, 8'd0, 8'd0);
      cyc = 1;
      @(negedge clk);
      while (!done4 && cyc < 40) begin
        @(negedge clk);
        cyc++;
      end
      check("b2b_latency", 32'(cyc), 32'd4);
      check("b2b_d", 32'(d4), 32'(b2b[k].exp_d));
      check("b2b_bf", 32'(bf4), 32'(b2b[k].exp_bf));
    end
    @(negedge clk);
    check("b2b_idle", 32'(busy4), 32'd0);

    // Asynchronous reset mid-SHIFT: everything clears at once, no done
    drive(1'b1, 8'd10, 8'd4);
    @(negedge clk);
    drive(1'b0, 8'd0, 8'd0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy4), 32'd0);
    check("arst_done", 32'(done4), 32'd0);
    check("arst_d", 32'(d4), 32'd0);
    check("arst_bf", 32'(bf4), 32'd0);
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done4) dones++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done4) dones++;
    end
    check("arst_no_done", 32'(dones), 32'd0);
    run_op('{8'd10, 8'd4, 8'd6, 1'b0});

    // Wider operands
    sel8 = 1'b1;
    for (int i = 0; i < 2; i++) run_op(vecs8[i]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
